tdes_sequencer: RTL

TDES_SEQUENCER -- requirements
Module: tdes_sequencer

---
 rtl/tdes_pkg.sv | 58 +++++
 rtl/tdes_watchdog.sv | 34 +++
 rtl/tdes_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tdes_pkg.sv
// Shared types and constants for the triple-DES pass sequencer.
// Includes the helpers that map a stage and mode onto the key and direction of that pass.
package tdes_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    S1_START = 3'd1,
    S1_WAIT  = 3'd2,
    S2_START = 3'd3,
    S2_WAIT  = 3'd4,
    S3_START = 3'd5,
    S3_WAIT  = 3'd6
  } tdes_state_t;

  localparam logic ENCRYPT         = 1'b0;
  localparam logic DECRYPT         = 1'b1;
  localparam int   TIMEOUT_DEFAULT = 31;

  function automatic logic is_start(input tdes_state_t s);
    return (s == S1_START) || (s == S2_START) || (s == S3_START);
  endfunction

  function automatic logic [1:0] stage_of(input tdes_state_t s);
    logic [1:0] stage;
    case (s)
      S1_START, S1_WAIT: stage = 2'd1;
      S2_START, S2_WAIT: stage = 2'd2;
      S3_START, S3_WAIT: stage = 2'd3;
      default:           stage = 2'd0;
    endcase
    return stage;
  endfunction

  // E-D-E walks key1..key3; D-E-D walks them in reverse, middle pass always key2
  function automatic logic [63:0] pass_key(input logic [1:0] stage, input logic mode,
                                           input logic [63:0] k1, input logic [63:0] k2,
                                           input logic [63:0] k3);
    logic [63:0] key;
    case (stage)
      2'd1:    key = (mode == DECRYPT) ? k3 : k1;
      2'd2:    key = k2;
      2'd3:    key = (mode == DECRYPT) ? k1 : k3;
      default: key = 64'd0;
    endcase
    return key;
  endfunction

  function automatic logic pass_decrypt(input logic [1:0] stage, input logic mode);
    logic dec;
    case (stage)
      2'd1, 2'd3: dec = mode;
      2'd2:       dec = ~mode;
      default:    dec = 1'b0;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/tdes_watchdog.sv
// Per-stage wait counter; expired flags the TIMEOUT-th consecutive counted cycle.
// Cleared by the sequencer while it sits in a START state.
module tdes_watchdog
  import tdes_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // wait-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign expired = count && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/tdes_sequencer.sv
// Triple-DES sequencer: drives one shared DES core through three chained passes
// (E-D-E or D-E-D) and holds the final block until the next accepted request.
module tdes_sequencer
  import tdes_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        enable,
  input  logic        encryptionType,
  input  logic [63:0] data,
  input  logic [63:0] key1,
  input  logic [63:0] key2,
  input  logic [63:0] key3,
  input  logic        desDone,
  input  logic [63:0] desDataOut,
  output logic        desStart,
  output logic        desDecrypt,
  output logic [63:0] desKey,
  output logic [63:0] desDataIn,
  output logic        outputEnable,
  output logic [63:0] outputData,
  output logic        busy,
  output logic        error
);

  tdes_state_t state, next_state;
  logic        accept, load_work, finish, timeout;
  logic        wd_clear, wd_count, wd_expired;
  logic        cap_mode, op_mode;
  logic [63:0] cap_key1, cap_key2, cap_key3, op_key1, op_key2, op_key3;
  logic [63:0] work;

  tdes_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (HCLK),
    .rst_n   (HRESET),
    .clear   (wd_clear),
    .count   (wd_count),
    .expired (wd_expired)
  );

  // next-state and control decode
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    load_work  = 1'b0;
    finish     = 1'b0;
    timeout    = 1'b0;
    wd_clear   = 1'b0;
    wd_count   = 1'b0;
    case (state)
      IDLE: begin
        wd_clear = 1'b1;
        if (enable) begin
          accept     = 1'b1;
          next_state = S1_START;
        end else begin
          next_state = IDLE;
        end
      end
      S1_START: begin wd_clear = 1'b1; next_state = S1_WAIT; end
      S2_START: begin wd_clear = 1'b1; next_state = S2_WAIT; end
      S3_START: begin wd_clear = 1'b1; next_state = S3_WAIT; end
      S1_WAIT, S2_WAIT: begin
        wd_count = 1'b1;
        if (desDone) begin
          load_work  = 1'b1;
          next_state = (state == S1_WAIT) ? S2_START : S3_START;
        end else if (wd_expired) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = state;
        end
      end
      S3_WAIT: begin
        wd_count = 1'b1;
        if (desDone) begin
          finish     = 1'b1;
          next_state = IDLE;
        end else if (wd_expired) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = S3_WAIT;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // operands as they will stand in the capture registers after this edge
  always_comb begin
    if (accept) begin
      op_mode = encryptionType;
      op_key1 = key1;
      op_key2 = key2;
      op_key3 = key3;
    end else begin
      op_mode = cap_mode;
      op_key1 = cap_key1;
      op_key2 = cap_key2;
      op_key3 = cap_key3;
    end
  end

  // state, capture, pass and result registers
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state        <= IDLE;
      cap_mode     <= ENCRYPT;
      cap_key1     <= 64'd0;
      cap_key2     <= 64'd0;
      cap_key3     <= 64'd0;
      work         <= 64'd0;
      desStart     <= 1'b0;
      desDecrypt   <= 1'b0;
      desKey       <= 64'd0;
      outputEnable <= 1'b0;
      outputData   <= 64'd0;
      busy         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state    <= next_state;
      busy     <= (next_state != IDLE);
      desStart <= is_start(next_state);
      cap_mode <= op_mode;
      cap_key1 <= op_key1;
      cap_key2 <= op_key2;
      cap_key3 <= op_key3;
      // the work register carries the captured block into stage 1, then each pass result
      if (accept) begin
        work <= data;
      end else if (load_work) begin
        work <= desDataOut;
      end
      if (is_start(next_state)) begin
        desKey     <= pass_key(stage_of(next_state), op_mode, op_key1, op_key2, op_key3);
        desDecrypt <= pass_decrypt(stage_of(next_state), op_mode);
      end
      if (accept) begin
        outputEnable <= 1'b0;
        error        <= 1'b0;
      end else if (finish) begin
        outputEnable <= 1'b1;
        outputData   <= desDataOut;
      end else if (timeout) begin
        error <= 1'b1;
      end
    end
  end

  assign desDataIn = work;

endmodule
